// File: rtl/pid_term_gen.sv
// pid_term_gen: PID front end computing error, saturating integral and first
// difference, then scaling each by its gain through one time-shared multiplier.
// Latency 4 cycles from accepted sample to out_valid; one result per 5 cycles.
// Backpressure: none; a sample while busy is dropped and flags sticky overrun.
//
// Ports: clk/rst_n (async active-low), ena (global stall), sample/setpoint/
// measurement (request), cfg_valid/cfg_sel/cfg_data (gain writes),
// p/i/d_contrib + out_valid (results), busy, overrun (status).
// Optional build macro: PID_ANTIWINDUP_EN freezes the integrator while the
// integral contribution is pinned at a rail and the error pushes further out.
module pid_term_gen #(
    parameter int W     = 6,
    parameter int ACC_W = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                sample,
    input  logic signed [W-1:0] setpoint,
    input  logic signed [W-1:0] measurement,
    input  logic                cfg_valid,
    input  logic [1:0]          cfg_sel,
    input  logic [3:0]          cfg_data,
    output logic signed [W-1:0] p_contrib,
    output logic signed [W-1:0] i_contrib,
    output logic signed [W-1:0] d_contrib,
    output logic                out_valid,
    output logic                busy,
    output logic                overrun
);

    // Product width: 5-bit zero-extended gain times an ACC_W-bit operand.
    localparam int PW    = ACC_W + 5;
    localparam int W_MAX = 2**(W-1) - 1;
    localparam int W_MIN = -(2**(W-1));
    localparam int A_MAX = 2**(ACC_W-1) - 1;
    localparam int A_MIN = -(2**(ACC_W-1));

    localparam logic signed [W-1:0] W_MAX_V = W'(W_MAX);
    localparam logic signed [W-1:0] W_MIN_V = W'(W_MIN);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ERR  = 3'd1,
        S_MP   = 3'd2,
        S_MI   = 3'd3,
        S_MD   = 3'd4
    } state_t;

    function automatic logic signed [W-1:0] sat_w(input logic signed [PW-1:0] v);
        if (v > $signed(PW'(W_MAX)))
            return W_MAX_V;
        else if (v < $signed(PW'(W_MIN)))
            return W_MIN_V;
        else
            return v[W-1:0];
    endfunction

    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] v);
        if (v > $signed((ACC_W+1)'(A_MAX)))
            return ACC_W'(A_MAX);
        else if (v < $signed((ACC_W+1)'(A_MIN)))
            return ACC_W'(A_MIN);
        else
            return v[ACC_W-1:0];
    endfunction

    state_t state_q, state_d;

    logic [3:0]                kp_q, ki_q, kd_q;
    logic [3:0]                kp_s_q, ki_s_q, kd_s_q;
    logic signed [W-1:0]       sp_q, meas_q;
    logic signed [W-1:0]       e_q, e_prev_q;
    logic signed [W:0]         de_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic signed [W-1:0]       p_stage_q, i_stage_q;
    logic signed [W-1:0]       p_contrib_q, i_contrib_q, d_contrib_q;
    logic                      out_valid_q, overrun_q;

    // ERR-state arithmetic.
    logic signed [W:0]         diff;
    logic signed [W-1:0]       e_now;
    logic signed [W:0]         de_now;
    logic signed [ACC_W:0]     acc_sum;
    logic signed [ACC_W-1:0]   acc_next;
    logic                      acc_freeze;

    assign diff     = (W+1)'(sp_q) - (W+1)'(meas_q);
    assign e_now    = sat_w(PW'(diff));
    assign de_now   = (W+1)'(e_now) - (W+1)'(e_prev_q);
    assign acc_sum  = (ACC_W+1)'(acc_q) + (ACC_W+1)'(e_now);
    assign acc_next = sat_acc(acc_sum);

`ifdef PID_ANTIWINDUP_EN
    // Hold the integrator while the published integral term sits on a rail
    // and the new error would drive it further into that rail.
    assign acc_freeze = ((i_contrib_q == W_MAX_V) && !e_now[W-1] && (e_now != '0)) ||
                        ((i_contrib_q == W_MIN_V) &&  e_now[W-1]);
`else
    assign acc_freeze = 1'b0;
`endif

    // Shared multiplier: operand pair chosen by the current FSM state.
    logic [3:0]              mul_g;
    logic signed [4:0]       gain_sx;
    logic signed [ACC_W-1:0] mul_x;
    logic signed [PW-1:0]    prod;
    logic signed [PW-1:0]    prod_sh;
    logic signed [W-1:0]     stage_now;

    always_comb begin
        mul_g = 4'd0;
        mul_x = '0;
        case (state_q)
            S_MP: begin
                mul_g = kp_s_q;
                mul_x = ACC_W'(e_q);
            end
            S_MI: begin
                mul_g = ki_s_q;
                mul_x = acc_q;
            end
            S_MD: begin
                mul_g = kd_s_q;
                mul_x = ACC_W'(de_q);
            end
            default: ;
        endcase
    end

    assign gain_sx   = {1'b0, mul_g};
    assign prod      = PW'(gain_sx) * PW'(mul_x);
    // Integral term uses a coarser scale than P and D.
    assign prod_sh   = (state_q == S_MI) ? (prod >>> 4) : (prod >>> 2);
    assign stage_now = sat_w(prod_sh);

    always_comb begin
        state_d = state_q;
        if (ena) begin
            case (state_q)
                S_IDLE:  if (sample) state_d = S_ERR;
                S_ERR:   state_d = S_MP;
                S_MP:    state_d = S_MI;
                S_MI:    state_d = S_MD;
                S_MD:    state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kp_q        <= 4'd4;
            ki_q        <= 4'd1;
            kd_q        <= 4'd0;
            kp_s_q      <= 4'd0;
            ki_s_q      <= 4'd0;
            kd_s_q      <= 4'd0;
            sp_q        <= '0;
            meas_q      <= '0;
            e_q         <= '0;
            e_prev_q    <= '0;
            de_q        <= '0;
            acc_q       <= '0;
            p_stage_q   <= '0;
            i_stage_q   <= '0;
            p_contrib_q <= '0;
            i_contrib_q <= '0;
            d_contrib_q <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            // Pulse is cleared even during a stall so it never stretches.
            out_valid_q <= 1'b0;
            if (ena) begin
                if (cfg_valid) begin
                    case (cfg_sel)
                        2'd0:    kp_q <= cfg_data;
                        2'd1:    ki_q <= cfg_data;
                        2'd2:    kd_q <= cfg_data;
                        default: ;
                    endcase
                end
                if (sample && (state_q != S_IDLE))
                    overrun_q <= 1'b1;
                case (state_q)
                    S_IDLE: begin
                        if (sample) begin
                            sp_q   <= setpoint;
                            meas_q <= measurement;
                            // Old register values: a same-edge write lands next time.
                            kp_s_q <= kp_q;
                            ki_s_q <= ki_q;
                            kd_s_q <= kd_q;
                        end
                    end
                    S_ERR: begin
                        e_q      <= e_now;
                        de_q     <= de_now;
                        e_prev_q <= e_now;
                        if (!acc_freeze)
                            acc_q <= acc_next;
                    end
                    S_MP: p_stage_q <= stage_now;
                    S_MI: i_stage_q <= stage_now;
                    S_MD: begin
                        p_contrib_q <= p_stage_q;
                        i_contrib_q <= i_stage_q;
                        d_contrib_q <= stage_now;
                        out_valid_q <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign p_contrib = p_contrib_q;
    assign i_contrib = i_contrib_q;
    assign d_contrib = d_contrib_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != S_IDLE);
    assign overrun   = overrun_q;

endmodule

// File: doc/pid_term_gen.md
# pid_term_gen

Front-end stage of the PID controller. It takes a setpoint and a measurement on a sample strobe and computes the error, a saturating integral and a first difference. It scales each term by a programmable gain and presents the three signed 6-bit contributions, `p_contrib`, `i_contrib` and `d_contrib`, to the PID summing stage downstream. A single shared multiplier is time-multiplexed by a small FSM.

## Interface
Parameters:
- `W`, 6: width of setpoint, measurement and each contribution (two's complement).
- `ACC_W`, 10: integrator accumulator width (signed).

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ena`  in  1  clock enable; low freezes all state and ignores `sample` and `cfg_valid`.
- `sample`  in  1  one-cycle strobe requesting a new computation.
- `setpoint`  in  W  signed target value.
- `measurement`  in  W  signed process value.
- `cfg_valid`  in  1  gain write strobe.
- `cfg_sel`  in  2  gain select: 0 = Kp, 1 = Ki, 2 = Kd, 3 = ignored.
- `cfg_data`  in  4  unsigned gain value.
- `p_contrib`  out  W  signed proportional term.
- `i_contrib`  out  W  signed integral term.
- `d_contrib`  out  W  signed derivative term.
- `out_valid`  out  1  one-cycle pulse: the three contributions were updated.
- `busy`  out  1  high while the FSM is not IDLE.
- `overrun`  out  1  sticky; set when `sample` arrives while busy. Cleared only by reset.

## Operation
Reset values:
- All contributions 0; `out_valid`, `busy` and `overrun` 0.
- Accumulator 0 and `e_prev` 0.
- Kp = 4, Ki = 1, Kd = 0.

Gain registers:
- Written on `cfg_valid` in any state.
- A snapshot is taken on sample acceptance, so a write during a computation takes effect from the next sample.

FSM states: IDLE → ERR → MP → MI → MD → IDLE.
- **IDLE:** on `sample`, capture `setpoint`, `measurement` and the gain snapshot, then go to ERR.
- **ERR:**
  - Compute `e = sat_W(setpoint − measurement)`, with the difference formed at W+1 bits.
  - Compute `de = e − e_prev`, at W+1 bits, not saturated.
  - Update `acc = sat_ACC(acc + e)` and `e_prev = e`.
- **MP:** `p_stage = sat_W((Kp·e) >>> 2)`.
- **MI:** `i_stage = sat_W((Ki·acc) >>> 4)`.
- **MD:**
  - `d_stage = sat_W((Kd·de) >>> 2)`.
  - On this transition to IDLE, copy all three stages to the outputs together and pulse `out_valid`.

Arithmetic rules:
- Gains are unsigned and zero-extended before the signed multiply.
- `>>>` is an arithmetic shift, so rounding is toward −∞.
- `sat_W` clamps to [−2^(W−1), 2^(W−1)−1]; `sat_ACC` clamps to [−512, 511].
- Outputs never wrap.

Boundary behaviour:
- `sample` while busy is ignored and sets `overrun`; the computation in flight is unaffected.
- `sample` together with `cfg_valid` in IDLE: the snapshot takes the pre-write gain.
- Reset mid-computation returns to IDLE with all reset values. No `out_valid` is produced.

## Timing
- `sample` accepted at edge N. Outputs and `out_valid` are registered at edge N+4; latency is 4 cycles.
- `busy` is high from edge N through edge N+4.
- The earliest next accepted `sample` is at edge N+5, so throughput is one result per 5 cycles.
- `out_valid` is high for exactly one cycle. Contributions hold their value between pulses.
- `ena` low stalls the FSM in place. Latency extends by the number of stalled cycles.

## Configuration
Macro `PID_ANTIWINDUP_EN`.
- **Defined:** in ERR the accumulator is not updated if either condition holds:
  - the current `i_contrib` equals +31 and `e > 0`;
  - the current `i_contrib` equals −32 and `e < 0`.

  `e_prev` still updates.
- **Undefined:** the accumulator always updates. It still saturates at ±ACC_W limits.

## Test plan
- **Reset:** assert `rst_n` low mid-MI → all outputs 0, `busy` 0. After release and a sample with gains left at reset values, setpoint 10, meas 3 → p = 7, i = 0, d = 0, `out_valid` 4 cycles after `sample`.
- **Integral:** Ki = 8, Kp = 0, Kd = 0; three samples with e = 4 → i = 2, 4, 6 on successive `out_valid` pulses.
- **Saturation and rounding:**
  - setpoint 31, meas −32, Kp = 15 → e clamps to 31, p = 31.
  - Kp = 1, e = −1 → p = −1 (floor).
- **Derivative:** Kd = 4; e = 0 then e = 5 then e = 5 → d = 0, 5, 0.
- **Overrun and gain timing:** `sample` at N+2 → `overrun` = 1 and remains set; the result matches the first sample only. A Kp write during busy does not affect the current p.
- **Anti-windup:** with `PID_ANTIWINDUP_EN`, Ki = 15 and e = 31 repeatedly:
  - i holds at 31 while the accumulator freezes;
  - switching to e = −31 drops i below 31 on the next result.

  Without the macro, the same sequence leaves i at 31 for several samples after the switch.
